// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam int         TIMEOUT_CW = 8;
endpackage

// File: rtl/mem_timeout_cnt.sv
// Access-wait counter: cleared outside ACCESS, counts un-acked cycles, flags terminal count.
module mem_timeout_cnt #(
    parameter int CW   = 8,
    parameter int TERM = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [CW-1:0] TERM_V = CW'(TERM);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expired = (count == TERM_V);
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack bus, global stall, misalign and timeout errors.
// Optional timeout on a missing bus_ack is enabled by defining MEM_ACC_TIMEOUT_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              pipe_stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              misalign_err,
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr
);
    state_t state;
    logic   access;
    logic   aligned;
    logic   expired;

    assign access  = mem_read | mem_write;
    assign aligned = ((mem_addr[1:0] & ALIGN_MASK) == 2'b00);

`ifdef MEM_ACC_TIMEOUT_EN
    mem_timeout_cnt #(
        .CW   (TIMEOUT_CW),
        .TERM (TIMEOUT_CYCLES - 1)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ACCESS),
        .enable  ((state == ACCESS) && !bus_ack),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Gated by reset so the stall drops immediately even if EX/MEM still holds an access.
    assign pipe_stall = !reset &&
                        (((state == IDLE) && access && aligned) || (state == ACCESS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            err_addr     <= '0;
        end else begin
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= mem_addr;
                            bus_wdata <= mem_wdata;
                            state     <= ACCESS;
                        end else begin
                            misalign_err <= 1'b1;
                            err_addr     <= mem_addr;
                        end
                    end
                end
                ACCESS: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            load_data  <= bus_rdata;
                            load_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (expired) begin
                        bus_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        err_addr <= bus_addr;
                        if (!bus_we) begin
                            load_data  <= '0;
                            load_valid <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                // EX/MEM still holds the finished instruction here, so no new access.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; timeout scenarios run when MEM_ACC_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        pipe_stall;
    logic [31:0] load_data;
    logic        load_valid, misalign_err, bus_err;
    logic [31:0] err_addr;

    int errors = 0;
    int checks = 0;
    int stall_cnt, req_cnt, lv_cnt, berr_cnt;

    mem_access_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .pipe_stall(pipe_stall), .load_data(load_data),
        .load_valid(load_valid), .misalign_err(misalign_err),
        .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pipe_stall) stall_cnt++;
        if (bus_req)    req_cnt++;
        if (load_valid) lv_cnt++;
        if (bus_err)    berr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts;
        stall_cnt = 0; req_cnt = 0; lv_cnt = 0; berr_cnt = 0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = wd;
    endtask

    initial begin
        reset = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        check("rst_req",   {31'b0, bus_req}, 32'd0);
        check("rst_stall", {31'b0, pipe_stall}, 32'd0);
        check("rst_ldata", load_data, 32'd0);
        check("rst_eaddr", err_addr, 32'd0);
        tick; reset = 1'b0; tick;

        // Load with ack in the first ACCESS cycle.
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0); clr_counts;
        #1 check("ld_stall_idle", {31'b0, pipe_stall}, 32'd1);
        tick; check("ld_addr", bus_addr, 32'h10);
        check("ld_we", {31'b0, bus_we}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        tick; bus_ack = 1'b0;
        check("ld_valid", {31'b0, load_valid}, 32'd1);
        check("ld_data", load_data, 32'h1234_5678);
        check("ld_done_stall", {31'b0, pipe_stall}, 32'd0);
        tick; drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        check("ld_stall_cnt", stall_cnt, 32'd2);
        check("ld_req_cnt", req_cnt, 32'd1);
        check("ld_lv_cnt", lv_cnt, 32'd1);

        // Store acked in the third ACCESS cycle.
        drive(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D); clr_counts;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("st_we", {31'b0, bus_we}, 32'd1);
            check("st_addr", bus_addr, 32'h20);
            check("st_wdata", bus_wdata, 32'hCAFE_F00D);
        end
        bus_ack = 1'b1;
        tick; bus_ack = 1'b0;
        tick; drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        check("st_stall_cnt", stall_cnt, 32'd4);
        check("st_req_cnt", req_cnt, 32'd3);
        check("st_lv_cnt", lv_cnt, 32'd0);

        // Misaligned load: error pulse only, load_data untouched.
        drive(1'b1, 1'b0, 32'h13, 32'h0); clr_counts;
        #1 check("mis_stall", {31'b0, pipe_stall}, 32'd0);
        tick; drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("mis_err", {31'b0, misalign_err}, 32'd1);
        check("mis_eaddr", err_addr, 32'h13);
        check("mis_req", {31'b0, bus_req}, 32'd0);
        tick;
        check("mis_pulse", {31'b0, misalign_err}, 32'd0);
        check("mis_ldata", load_data, 32'h1234_5678);

        // Stray ack while idle is ignored.
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick; bus_ack = 1'b0;
        check("stray_lv", {31'b0, load_valid}, 32'd0);
        check("stray_ldata", load_data, 32'h1234_5678);

        // Back-to-back load then read+write (treated as a write).
        drive(1'b1, 1'b0, 32'h40, 32'h0); clr_counts;
        tick; bus_ack = 1'b1; bus_rdata = 32'hA5A5_5A5A;
        tick; bus_ack = 1'b0;
        check("b2b_ld_data", load_data, 32'hA5A5_5A5A);
        tick; drive(1'b1, 1'b1, 32'h44, 32'h0BAD_F00D);
        #1 check("b2b_2nd_stall", {31'b0, pipe_stall}, 32'd1);
        tick;
        check("b2b_addr", bus_addr, 32'h44);
        check("b2b_we", {31'b0, bus_we}, 32'd1);
        bus_ack = 1'b1;
        tick; bus_ack = 1'b0;
        tick; drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        check("b2b_req_cnt", req_cnt, 32'd2);
        check("b2b_lv_cnt", lv_cnt, 32'd1);
        check("b2b_stall_cnt", stall_cnt, 32'd4);

`ifdef MEM_ACC_TIMEOUT_EN
        // No ack: expires after four ACCESS cycles.
        drive(1'b1, 1'b0, 32'h80, 32'h0); clr_counts;
        for (int i = 0; i < 4; i++) tick;
        check("to_req_held", {31'b0, bus_req}, 32'd1);
        tick;
        check("to_req_drop", {31'b0, bus_req}, 32'd0);
        check("to_berr", {31'b0, bus_err}, 32'd1);
        check("to_lv", {31'b0, load_valid}, 32'd1);
        check("to_ldata", load_data, 32'd0);
        check("to_eaddr", err_addr, 32'h80);
        tick; drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        check("to_req_cnt", req_cnt, 32'd4);
        // Ack on the expiring cycle completes normally.
        drive(1'b1, 1'b0, 32'h84, 32'h0); clr_counts;
        for (int i = 0; i < 4; i++) tick;
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        tick; bus_ack = 1'b0;
        check("tie_berr", {31'b0, bus_err}, 32'd0);
        check("tie_ldata", load_data, 32'h5555_AAAA);
        tick; drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        check("tie_berr_cnt", berr_cnt, 32'd0);
`else
        // No ack: request must stay up indefinitely and bus_err never fires.
        drive(1'b1, 1'b0, 32'h80, 32'h0); clr_counts;
        for (int i = 0; i < 20; i++) tick;
        check("nto_req_held", {31'b0, bus_req}, 32'd1);
        check("nto_berr_cnt", berr_cnt, 32'd0);
        reset = 1'b1; #1; reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick;
`endif

        // Reset while an access is in flight.
        drive(1'b1, 1'b0, 32'h100, 32'h0); clr_counts;
        tick; tick;
        check("mid_req_pre", {31'b0, bus_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_req", {31'b0, bus_req}, 32'd0);
        check("mid_stall", {31'b0, pipe_stall}, 32'd0);
        check("mid_addr", bus_addr, 32'd0);
        check("mid_ldata", load_data, 32'd0);
        check("mid_lv", {31'b0, load_valid}, 32'd0);
        check("mid_eaddr", err_addr, 32'd0);
        tick; tick;
        check("mid_lv_cnt", lv_cnt, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
